id_branch_unit: RTL
===================

# id_branch_unit

Decode-stage front end of the P5 pipeline, sitting between instruction fetch and the rest of D. It registers the fetched instruction and PC (IF/ID register), decodes control-transfer instructions, and compares the forwarded operands. It returns the next-PC request (jumpOp, zero, offset, instr_index, rsIn, D_pcPlus4) to the fetch unit in the same cycle. It also keeps a taken-transfer counter for performance checks.

## Interface
Parameters:
- RESET_PC, 32'h00003000, PC value loaded into D_pc on reset.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- enable  in  1  IF/ID register load enable; 0 = stall, hold all D registers.
- F_instr  in  32  instruction word from fetch.
- F_pc  in  32  PC of F_instr.
- D_rsData  in  32  forwarded GPR[rs] of D_instr, already resolved by the hazard unit.
- D_rtData  in  32  forwarded GPR[rt] of D_instr.
- D_instr  out  32  registered instruction.
- D_pc  out  32  registered PC.
- D_pcPlus4  out  32  D_pc + 4, to fetch.
- D_pcPlus8  out  32  D_pc + 8, link value for jal.
- jumpOp  out  3  0 none, 1 beq, 2 jal, 3 jr; 4–7 never driven.
- zero  out  1  D_rsData == D_rtData.
- offset  out  16  D_instr[15:0].
- instr_index  out  26  D_instr[25:0].
- rsIn  out  32  D_rsData, jr target.
- taken_cnt  out  32  count of committed taken transfers.

## Operation
- IF/ID register, priority reset > enable:
  - reset: D_instr ← 0 (nop), D_pc ← RESET_PC.
  - enable = 1: D_instr ← F_instr, D_pc ← F_pc.
  - enable = 0: D_instr and D_pc hold.
- Decode is combinational from D_instr. opcode = [31:26], funct = [5:0].
  - opcode 6'b000100 → jumpOp 1 (beq).
  - opcode 6'b000011 → jumpOp 2 (jal).
  - opcode 0 with funct 6'b001000 → jumpOp 3 (jr).
  - Everything else, including nop 0x00000000 → jumpOp 0.
- zero is the 32-bit equality of the forwarded operands. It is driven for every instruction; fetch uses it only when jumpOp = 1.
- offset, instr_index and rsIn are pure field extracts. Sign-extension and shifting are done by fetch, not here.
- D_pcPlus4 and D_pcPlus8 use 32-bit add and wrap modulo 2^32.
- Delay-slot architecture: the slot instruction is not flushed. This block has no flush path.
- taken_cnt:
  - Increments by 1 on a rising edge when enable = 1 and (jumpOp ∈ {2,3} or (jumpOp = 1 and zero = 1)).
  - Wraps 32'hFFFFFFFF → 0.
  - Cleared by reset.
  - A branch held across N stall cycles is counted once, on the cycle enable is 1.

## Timing
- IF/ID register latency 1 cycle. All next-PC outputs are combinational from D registers and forwarded inputs, valid in the same cycle. Fetch samples them at the next edge.
- Reset values: D_instr 0, D_pc RESET_PC, D_pcPlus4 RESET_PC+4, D_pcPlus8 RESET_PC+8, jumpOp 0, offset 0, instr_index 0, taken_cnt 0.
- zero and rsIn track the D_rsData/D_rtData inputs even during reset.
- Reset asserted mid-stall: reset wins, and the next cycle shows the nop.
- Stall with a branch in D: outputs stay constant apart from zero and rsIn, which follow late-resolved forwarding. taken_cnt does not advance.
- Combinational path D_rsData/D_rtData → zero → fetch npc mux is the critical path. It must contain no other logic.

## Structure
- Shared package mips_defs holds:
  - opcode/funct constants: OP_SPECIAL, OP_BEQ, OP_JAL, FN_JR.
  - jumpOp encoding: JOP_NONE=0, JOP_BEQ=1, JOP_JAL=2, JOP_JR=3.
  - RESET_PC default.
- Fetch and the hazard unit import the same constants.
- One sub-module, d_cmp: 32-bit equality comparator producing zero. It is kept separate so it can later be extended to bne/blez.

## Test plan
- Reset: hold reset 2 cycles with F_instr=0x10220003 → D_instr=0, D_pc=0x3000, D_pcPlus4=0x3004, jumpOp=0, taken_cnt=0.
- beq taken: F_pc=0x3004, F_instr=0x10220003, D_rsData=D_rtData=5, enable=1 → next cycle jumpOp=1, zero=1, offset=0x0003, D_pcPlus4=0x3008, taken_cnt increments to 1.
- beq not taken: same instruction with rs=5, rt=6 → jumpOp=1, zero=0, taken_cnt unchanged.
- jal/jr:
  - F_instr=0x0C000C04 at 0x3010 → jumpOp=2, instr_index=0x0000C04, D_pcPlus8=0x3018.
  - Then 0x03E00008 with D_rsData=0x3018 → jumpOp=3, rsIn=0x3018.
  - taken_cnt +2 over the two instructions.
- Stall: beq taken in D, enable=0 for 3 cycles while F_instr changes → D_instr stays 0x10220003, taken_cnt +1 only on the enable=1 cycle.
- Wrap and reset mid-operation:
  - Preload taken_cnt to 0xFFFFFFFF via 2^32−1 counted transfers (or force), then a taken jal → taken_cnt=0.
  - Reset during enable=0 → D_instr=0 next cycle.

Source files
------------

// File: rtl/mips_defs.sv
`default_nettype none
// ============================================================================
// Package     : mips_defs
// Description : Opcode/funct constants and jumpOp encoding for the P5 pipeline.
// Revision    : 1.0
// ============================================================================
package mips_defs;

    localparam logic [5:0]  OP_SPECIAL       = 6'b000000;
    localparam logic [5:0]  OP_BEQ           = 6'b000100;
    localparam logic [5:0]  OP_JAL           = 6'b000011;
    localparam logic [5:0]  FN_JR            = 6'b001000;

    localparam logic [2:0]  JOP_NONE         = 3'd0;
    localparam logic [2:0]  JOP_BEQ          = 3'd1;
    localparam logic [2:0]  JOP_JAL          = 3'd2;
    localparam logic [2:0]  JOP_JR           = 3'd3;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    // Maps an instruction word to its control-transfer class.
    function automatic logic [2:0] decode_jop(input logic [31:0] instr);
        logic [2:0] jop;
        jop = JOP_NONE;
        if (instr[31:26] == OP_BEQ)
            jop = JOP_BEQ;
        else if (instr[31:26] == OP_JAL)
            jop = JOP_JAL;
        else if (instr[31:26] == OP_SPECIAL && instr[5:0] == FN_JR)
            jop = JOP_JR;
        return jop;
    endfunction

endpackage
`default_nettype wire

// File: rtl/d_cmp.sv
`default_nettype none
// ============================================================================
// Module      : d_cmp
// Description : Decode-stage operand comparator; equality only for now.
// Revision    : 1.0
// ============================================================================
module d_cmp (
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        zero
);

    assign zero = (rs_data == rt_data);

endmodule
`default_nettype wire

// File: rtl/id_branch_unit.sv
`default_nettype none
// ============================================================================
// Module      : id_branch_unit
// Description : IF/ID register, control-transfer decode and next-PC request.
// Revision    : 1.0
// ============================================================================
module id_branch_unit
    import mips_defs::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] F_instr,
    input  logic [31:0] F_pc,
    input  logic [31:0] D_rsData,
    input  logic [31:0] D_rtData,
    output logic [31:0] D_instr,
    output logic [31:0] D_pc,
    output logic [31:0] D_pcPlus4,
    output logic [31:0] D_pcPlus8,
    output logic [2:0]  jumpOp,
    output logic        zero,
    output logic [15:0] offset,
    output logic [25:0] instr_index,
    output logic [31:0] rsIn,
    output logic [31:0] taken_cnt
);

    logic [31:0] r_instr;
    logic [31:0] r_pc;
    logic [31:0] r_taken_cnt;
    logic [2:0]  w_jop;
    logic        w_zero;
    logic        w_taken;

    // Comparator output feeds fetch directly; nothing else sits on this path.
    d_cmp u_d_cmp (
        .rs_data (D_rsData),
        .rt_data (D_rtData),
        .zero    (w_zero)
    );

    assign w_jop   = decode_jop(r_instr);
    assign w_taken = (w_jop == JOP_JAL) || (w_jop == JOP_JR) ||
                     ((w_jop == JOP_BEQ) && w_zero);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_instr     <= 32'h0000_0000;
            r_pc        <= RESET_PC;
            r_taken_cnt <= 32'h0000_0000;
        end else if (enable) begin
            r_instr <= F_instr;
            r_pc    <= F_pc;
            if (w_taken)
                r_taken_cnt <= r_taken_cnt + 32'd1;
        end
    end

    assign D_instr     = r_instr;
    assign D_pc        = r_pc;
    assign D_pcPlus4   = r_pc + 32'd4;
    assign D_pcPlus8   = r_pc + 32'd8;
    assign jumpOp      = w_jop;
    assign zero        = w_zero;
    assign offset      = r_instr[15:0];
    assign instr_index = r_instr[25:0];
    assign rsIn        = D_rsData;
    assign taken_cnt   = r_taken_cnt;

endmodule
`default_nettype wire
